// File: rtl/axis_pool_window_gen.sv
// rtl/axis_pool_window_gen.sv - raster-to-2x2-window reorder stage ahead of the AXI-Stream maxpool
//
// Purpose: accepts a row-major, channel-after-channel feature map and re-emits
// it as 2x2 pooling windows in the order p[r][c], p[r][c+1], p[r+1][c], p[r+1][c+1].
//
// Ports:
//   aclk           clock, rising edge
//   areset         synchronous active-high reset
//   s_axis_tdata   raster-order input pixel
//   s_axis_tvalid  input pixel valid
//   s_axis_tready  block can accept a pixel this cycle
//   m_axis_tdata   window-ordered output pixel (registered)
//   m_axis_tvalid  output pixel valid (registered)
//   m_axis_tready  downstream accepts the output
//   m_axis_tlast   last beat of the last window of channel N-1 (registered)

module axis_pool_window_gen #(
  parameter int WIDTH = 8,
  parameter int Win   = 28,
  parameter int Hin   = 28,
  parameter int N     = 6
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  // col and row must be able to hold Win / Hin transiently after the +2 step
  localparam int CW = $clog2(Win + 1);
  localparam int IW = $clog2(Win);
  localparam int RW = $clog2(Hin + 1);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_FILL_EVEN = 3'd0;
  localparam logic [2:0] S_ODD_A     = 3'd1;
  localparam logic [2:0] S_ODD_B     = 3'd2;
  localparam logic [2:0] S_EMIT0     = 3'd3;
  localparam logic [2:0] S_EMIT1     = 3'd4;
  localparam logic [2:0] S_EMIT2     = 3'd5;
  localparam logic [2:0] S_EMIT3     = 3'd6;
  localparam logic [2:0] S_DROP_ROW  = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NW-1:0]    ch_q, ch_d;
  logic [WIDTH-1:0] hold0_q, hold0_d;
  logic [WIDTH-1:0] hold1_q, hold1_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;

  // Even row of the current row pair
  logic [WIDTH-1:0] buf_q [Win];

  logic             s_acc;
  logic             m_hs;
  logic             buf_we;
  logic [IW-1:0]    rd_idx0;
  logic [IW-1:0]    rd_idx1;
  logic [CW-1:0]    col_p2;
  logic [RW-1:0]    row_p2;
  logic             last_win;
  logic             end_row;
  logic             end_ch;

  always_comb begin
    s_axis_tready = 1'b0;
    if (!areset) begin
      s_axis_tready = (state_q == S_FILL_EVEN) || (state_q == S_ODD_A) ||
                      (state_q == S_ODD_B) || (state_q == S_DROP_ROW);
    end
  end

  assign s_acc   = s_axis_tvalid && s_axis_tready;
  assign m_hs    = tvalid_q && m_axis_tready;
  assign rd_idx0 = IW'(col_q);
  assign rd_idx1 = IW'(col_q + CW'(1));
  assign col_p2  = col_q + CW'(2);
  assign row_p2  = row_q + RW'(2);

  // The final window is the one whose +2 steps reach (or pass to the odd
  // leftover of) the right edge and the bottom edge in the last channel.
  assign last_win = (ch_q == NW'(N - 1)) &&
                    (row_p2 >= RW'(Hin - 1)) &&
                    (col_p2 >= CW'(Win - 1));

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    ch_d     = ch_q;
    hold0_d  = hold0_q;
    hold1_d  = hold1_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    buf_we   = 1'b0;
    end_row  = 1'b0;
    end_ch   = 1'b0;

    case (state_q)
      S_FILL_EVEN: begin
        if (s_acc) begin
          buf_we = 1'b1;
          if (col_q == CW'(Win - 1)) begin
            col_d   = '0;
            state_d = S_ODD_A;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_ODD_A: begin
        if (s_acc) begin
          // Unpaired odd-row pixel at the right edge of an odd-width map
          if (col_q == CW'(Win - 1)) begin
            end_row = 1'b1;
          end else begin
            hold0_d = s_axis_tdata;
            state_d = S_ODD_B;
          end
        end
      end
      S_ODD_B: begin
        if (s_acc) begin
          hold1_d  = s_axis_tdata;
          tdata_d  = buf_q[rd_idx0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = S_EMIT0;
        end
      end
      S_EMIT0: begin
        if (m_hs) begin
          tdata_d = buf_q[rd_idx1];
          state_d = S_EMIT1;
        end
      end
      S_EMIT1: begin
        if (m_hs) begin
          tdata_d = hold0_q;
          state_d = S_EMIT2;
        end
      end
      S_EMIT2: begin
        if (m_hs) begin
          tdata_d = hold1_q;
          tlast_d = last_win;
          state_d = S_EMIT3;
        end
      end
      S_EMIT3: begin
        if (m_hs) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (col_p2 == CW'(Win)) begin
            end_row = 1'b1;
          end else begin
            col_d   = col_p2;
            state_d = S_ODD_A;
          end
        end
      end
      S_DROP_ROW: begin
        if (s_acc) begin
          if (col_q == CW'(Win - 1)) begin
            col_d  = '0;
            end_ch = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_FILL_EVEN;
    endcase

    if (end_row) begin
      col_d = '0;
      row_d = row_p2;
      if (row_p2 == RW'(Hin - 1)) begin
        state_d = S_DROP_ROW;
      end else if (row_p2 == RW'(Hin)) begin
        end_ch = 1'b1;
      end else begin
        state_d = S_FILL_EVEN;
      end
    end

    if (end_ch) begin
      row_d   = '0;
      ch_d    = (ch_q == NW'(N - 1)) ? '0 : ch_q + NW'(1);
      state_d = S_FILL_EVEN;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_FILL_EVEN;
      col_q    <= '0;
      row_q    <= '0;
      ch_q     <= '0;
      hold0_q  <= '0;
      hold1_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ch_q     <= ch_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  // Write is gated by s_axis_tready, which is low during reset
  always_ff @(posedge aclk) begin
    if (buf_we) begin
      buf_q[rd_idx0] <= s_axis_tdata;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pool_window_gen.sv
// tb/tb_axis_pool_window_gen.sv - scoreboard bench for axis_pool_window_gen over several geometries

module tb_axis_pool_window_gen;

  logic       aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       areset;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic [1:0] sel;
  int         mode;
  logic       tready_manual;
  logic       pat_q = 1'b1;
  int         cyc = 0;
  logic       m_tready;

  logic [3:0] s_tvalid_v, s_tready_v, m_tvalid_v, m_tlast_v;
  logic [7:0] m_tdata_a [4];
  logic       s_tready, m_tvalid, m_tlast;
  logic [7:0] m_tdata;

  assign s_tvalid_v = s_tvalid ? (4'b0001 << sel) : 4'b0000;
  assign m_tready   = (mode == 3) ? tready_manual : pat_q;
  assign s_tready   = s_tready_v[sel];
  assign m_tvalid   = m_tvalid_v[sel];
  assign m_tlast    = m_tlast_v[sel];
  assign m_tdata    = m_tdata_a[sel];

  axis_pool_window_gen #(.WIDTH(8), .Win(4), .Hin(4), .N(1)) u0 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_v[0]),
    .s_axis_tready(s_tready_v[0]), .m_axis_tdata(m_tdata_a[0]), .m_axis_tvalid(m_tvalid_v[0]),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_v[0]));
  axis_pool_window_gen #(.WIDTH(8), .Win(5), .Hin(5), .N(1)) u1 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_v[1]),
    .s_axis_tready(s_tready_v[1]), .m_axis_tdata(m_tdata_a[1]), .m_axis_tvalid(m_tvalid_v[1]),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_v[1]));
  axis_pool_window_gen #(.WIDTH(8), .Win(4), .Hin(2), .N(2)) u2 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_v[2]),
    .s_axis_tready(s_tready_v[2]), .m_axis_tdata(m_tdata_a[2]), .m_axis_tvalid(m_tvalid_v[2]),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_v[2]));
  axis_pool_window_gen #(.WIDTH(8), .Win(28), .Hin(28), .N(6)) u3 (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_v[3]),
    .s_axis_tready(s_tready_v[3]), .m_axis_tdata(m_tdata_a[3]), .m_axis_tvalid(m_tvalid_v[3]),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_v[3]));

  // Downstream ready: mode 0 always, 1 repeating 1,0,0,1, 2 random, 3 manual
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    case (mode)
      1:       pat_q <= ((cyc % 4) == 3) || ((cyc % 4) == 2);
      2:       pat_q <= ($urandom_range(3) != 0);
      default: pat_q <= 1'b1;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard entries are {tlast, tdata}
  logic [8:0] exp_q [$];
  int         beat_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic [8:0] mon_e;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (m_tvalid)
        check(s_tready == 1'b0, "input_ready_during_emit", 32'(s_tready), 32'd0);
      if (prev_stall)
        check(m_tvalid && (m_tdata == prev_data) && (m_tlast == prev_last), "stall_stable",
              32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, prev_last, prev_data}));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'({m_tlast, m_tdata}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check({m_tlast, m_tdata} == mon_e, "beat", 32'({m_tlast, m_tdata}), 32'(mon_e));
        end
        beat_cnt <= beat_cnt + 1;
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_last  <= m_tlast;
    end
  end

  // Reference: gather each 2x2 window directly from the frame array
  task automatic model_push(input int w, input int h, input int nc, input logic [7:0] pix [$]);
    int r, c;
    logic lastb;
    for (int ch = 0; ch < nc; ch++)
      for (int wy = 0; wy < h / 2; wy++)
        for (int wx = 0; wx < w / 2; wx++)
          for (int k = 0; k < 4; k++) begin
            r = 2 * wy + k / 2;
            c = 2 * wx + k % 2;
            lastb = (ch == nc - 1) && (wy == h / 2 - 1) && (wx == w / 2 - 1) && (k == 3);
            exp_q.push_back({lastb, pix[ch * w * h + r * w + c]});
          end
  endtask

  task automatic send_pixel(input logic [7:0] d, input int gap, output bit got, output bit tvb);
    int n;
    while ($urandom_range(99) < gap) begin
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1;
    end
    s_tdata  = d;
    s_tvalid = 1'b1;
    got = 1'b0;
    tvb = 1'b0;
    n = 0;
    while (!got && n < 2000) begin
      @(negedge aclk);
      got = s_tready;
      tvb = m_tvalid;
      @(posedge aclk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    if (!got) check(1'b0, "accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 5000 && exp_q.size() != 0; k++) @(posedge aclk);
    #1;
    check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input logic [1:0] s, input int w, input int h, input int nc,
                           input bit seq, input int gap, input bit lat_chk);
    logic [7:0] pix [$];
    int  b0;
    bit  got, tvb;
    sel = s;
    for (int i = 0; i < w * h * nc; i++) pix.push_back(seq ? 8'(i) : 8'($urandom));
    model_push(w, h, nc, pix);
    b0 = beat_cnt;
    for (int i = 0; i < pix.size(); i++) begin
      send_pixel(pix[i], gap, got, tvb);
      if (lat_chk && i == 5) begin
        check(!tvb, "tvalid_before_p5_accept", 32'(tvb), 32'd0);
        check(m_tvalid, "tvalid_after_p5_accept", 32'(m_tvalid), 32'd1);
      end
    end
    drain();
    check(beat_cnt - b0 == 4 * (w / 2) * (h / 2) * nc, "beat_count",
          32'(beat_cnt - b0), 32'(4 * (w / 2) * (h / 2) * nc));
    check(s_tready == 1'b1, "ready_after_frame", 32'(s_tready), 32'd1);
  endtask

  initial begin
    logic [7:0] pix [$];
    bit got, tvb;
    areset = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    sel = 2'd0;
    mode = 0;
    tready_manual = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check(m_tvalid_v == 4'b0 && m_tlast_v == 4'b0, "reset_valid_last",
          32'({m_tvalid_v, m_tlast_v}), 32'd0);
    check(m_tdata_a[0] == 8'd0 && m_tdata_a[3] == 8'd0, "reset_data",
          32'({m_tdata_a[0], m_tdata_a[3]}), 32'd0);
    check(s_tready_v == 4'b0, "reset_sready", 32'(s_tready_v), 32'd0);
    areset = 1'b0;
    #1;
    check(s_tready_v == 4'hf, "idle_sready", 32'(s_tready_v), 32'hf);

    run_frame(2'd0, 4, 4, 1, 1'b1, 0, 1'b1);
    mode = 1;
    run_frame(2'd0, 4, 4, 1, 1'b1, 0, 1'b0);
    mode = 0;
    run_frame(2'd1, 5, 5, 1, 1'b1, 0, 1'b0);
    run_frame(2'd2, 4, 2, 2, 1'b1, 0, 1'b0);
    run_frame(2'd2, 4, 2, 2, 1'b0, 20, 1'b0);
    mode = 2;
    run_frame(2'd3, 28, 28, 6, 1'b0, 40, 1'b0);

    // Reset while the third beat of the first window is stalled
    mode = 3;
    tready_manual = 1'b0;
    sel = 2'd0;
    for (int i = 0; i < 16; i++) pix.push_back(8'(i));
    model_push(4, 4, 1, pix);
    for (int i = 0; i < 6; i++) send_pixel(pix[i], 0, got, tvb);
    tready_manual = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    tready_manual = 1'b0;
    check(m_tvalid && m_tdata == 8'd4, "emit2_before_reset", 32'({m_tvalid, m_tdata}), 32'h104);
    areset = 1'b1;
    @(negedge aclk);
    check(s_tready == 1'b0, "sready_in_reset", 32'(s_tready), 32'd0);
    @(posedge aclk);
    #1;
    check(!m_tvalid && !m_tlast, "out_after_reset", 32'({m_tvalid, m_tlast}), 32'd0);
    areset = 1'b0;
    #1;
    check(s_tready == 1'b1, "sready_after_reset", 32'(s_tready), 32'd1);
    exp_q.delete();
    mode = 0;
    run_frame(2'd0, 4, 4, 1, 1'b1, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
